// File: rtl/cpu_ctrl_pkg.sv
// Shared controller/divider constants: div_unit state encoding, widths,
// function codes and the fixed divide latency the controller waits on.
package cpu_ctrl_pkg;

    localparam int DIV_WIDTH   = 32;
    localparam int DIV_LATENCY = 33;

    localparam logic [5:0] DIV_func  = 6'h1a;
    localparam logic [5:0] DIVM_func = 6'h1b;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_RUN  = 2'b01,
        DIV_FIX  = 2'b10
    } div_state_t;

endpackage

// File: rtl/div_unit_if.sv
// Start/operand/result bundle between the controller (master) and div_unit (slave).
interface div_unit_if #(
    parameter int WIDTH = 32
);
    logic             DivCtrl;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] Lo;
    logic [WIDTH-1:0] Hi;
    logic             done;
    logic             busy;
    logic             divZero;

    modport master (
        output DivCtrl, dividend, divisor,
        input  Lo, Hi, done, busy, divZero
    );

    modport slave (
        input  DivCtrl, dividend, divisor,
        output Lo, Hi, done, busy, divZero
    );
endinterface

// File: rtl/div_step.sv
// One restoring shift-subtract iteration on magnitudes: produces one quotient bit.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   i_rem,
    input  logic [WIDTH-1:0] i_quo,
    input  logic [WIDTH-1:0] i_dvs,
    output logic [WIDTH:0]   o_rem,
    output logic [WIDTH-1:0] o_quo
);
    logic [WIDTH+1:0] w_shift;
    logic [WIDTH+1:0] w_trial;

    // One extra guard bit so a negative trial shows up in the MSB.
    assign w_shift = {i_rem, i_quo[WIDTH-1]};
    assign w_trial = w_shift - {2'b00, i_dvs};

    always_comb begin
        o_rem = w_shift[WIDTH:0];
        o_quo = {i_quo[WIDTH-2:0], 1'b0};
        if (!w_trial[WIDTH+1]) begin
            o_rem = w_trial[WIDTH:0];
            o_quo = {i_quo[WIDTH-2:0], 1'b1};
        end
    end
endmodule

// File: rtl/div_unit.sv
// Multi-cycle signed divider: magnitudes are divided over WIDTH cycles, signs
// are reapplied in FIX. Lo = quotient (toward zero), Hi = remainder (dividend sign).
module div_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic       clk,
    input  logic       reset,
    div_unit_if.slave  bus
);
    div_state_t       r_state;
    logic [WIDTH:0]   r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dvs;
    logic             r_sq;
    logic             r_sr;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_hi;
    logic             r_done;
    logic             r_busy;
    logic             r_divzero;

    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [WIDTH:0]   w_rem;
    logic [WIDTH-1:0] w_quo;

    // Two's-complement magnitude; the most negative value maps to itself as unsigned.
    assign w_abs_a = bus.dividend[WIDTH-1] ? (~bus.dividend + 1'b1) : bus.dividend;
    assign w_abs_b = bus.divisor[WIDTH-1]  ? (~bus.divisor  + 1'b1) : bus.divisor;

    div_step #(.WIDTH(WIDTH)) u_step (
        .i_rem (r_rem),
        .i_quo (r_quo),
        .i_dvs (r_dvs),
        .o_rem (w_rem),
        .o_quo (w_quo)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= DIV_IDLE;
            r_rem     <= '0;
            r_quo     <= '0;
            r_dvs     <= '0;
            r_sq      <= 1'b0;
            r_sr      <= 1'b0;
            r_cnt     <= '0;
            r_lo      <= '0;
            r_hi      <= '0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
            r_divzero <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_divzero <= 1'b0;
            case (r_state)
                DIV_IDLE: begin
                    if (bus.DivCtrl) begin
                        if (bus.divisor == '0) begin
                            r_divzero <= 1'b1;
                        end else begin
                            r_quo   <= w_abs_a;
                            r_dvs   <= w_abs_b;
                            r_rem   <= '0;
                            r_sq    <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                            r_sr    <= bus.dividend[WIDTH-1];
                            r_cnt   <= '0;
                            r_busy  <= 1'b1;
                            r_state <= DIV_RUN;
                        end
                    end
                end
                DIV_RUN: begin
                    r_rem <= w_rem;
                    r_quo <= w_quo;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(WIDTH-1))
                        r_state <= DIV_FIX;
                end
                DIV_FIX: begin
                    r_lo    <= r_sq ? (~r_quo + 1'b1) : r_quo;
                    r_hi    <= r_sr ? (~r_rem[WIDTH-1:0] + 1'b1) : r_rem[WIDTH-1:0];
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= DIV_IDLE;
                end
                default: r_state <= DIV_IDLE;
            endcase
        end
    end

    assign bus.Lo      = r_lo;
    assign bus.Hi      = r_hi;
    assign bus.done    = r_done;
    assign bus.busy    = r_busy;
    assign bus.divZero = r_divzero;
endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle signed 32-bit divider. It is the responder to the controller's DivCtrl start request for DIV and DIVM.
- Datapath muxes (DivSrcA/DivSrcB) supply the operands. The unit returns quotient (Lo) and remainder (Hi) to the Hi/Lo registers, with a one-cycle done pulse.
- It also raises divZero toward the controller's DIV_ZERO exception state.
- It is a restoring shift-subtract engine: one quotient bit per cycle.

Parameters:
- WIDTH, 32, operand/result width in bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- DivCtrl  input  1  start request; sampled only in IDLE.
- dividend  input  WIDTH  signed dividend (A), sampled on the start edge.
- divisor  input  WIDTH  signed divisor (B), sampled on the start edge.
- Lo  output  WIDTH  quotient, registered.
- Hi  output  WIDTH  remainder, registered.
- done  output  1  one-cycle pulse; Hi/Lo are valid from this cycle onward.
- busy  output  1  high while not IDLE.
- divZero  output  1  one-cycle pulse on a divide-by-zero request.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on reset.
- Reset values: Lo=0, Hi=0, done=0, busy=0, divZero=0, state=IDLE, counter=0, internal registers=0.
- Reset dominates all other inputs. A reset arriving mid-operation aborts the division; no done or divZero pulse follows.
- States: IDLE, RUN, FIX.
- IDLE:
  - With DivCtrl=0, the unit holds.
  - With DivCtrl=1 and divisor==0 at edge E0: divZero=1 for the cycle after E0. State stays IDLE. Hi/Lo are unchanged; done stays 0.
  - With DivCtrl=1 and divisor!=0 at edge E0:
    - Latch |dividend| into the quotient shift register.
    - Latch |divisor|, and clear the partial remainder (WIDTH+1 bits).
    - Latch sq = sign(dividend) XOR sign(divisor) and sr = sign(dividend).
    - Set counter=0 and go to RUN; busy=1 from E0.
- RUN (edges E1..E32), one iteration per edge:
  - Shift {rem, quo} left by 1.
  - Compute trial = rem - |divisor|.
  - If trial >= 0: rem=trial and quo[0]=1. Otherwise rem is unchanged and quo[0]=0.
  - counter increments each edge. At counter==WIDTH-1 the transition goes to FIX.
- FIX (edge E33):
  - Lo = sq ? -quo : quo.
  - Hi = sr ? -rem : rem.
  - done=1 for exactly the cycle after E33. State returns to IDLE and busy=0 after E33.
- Latency: start edge to done is 33 edges.
- Hi/Lo hold their last result until the next FIX or reset. They never change during RUN.
- Sign and width rules:
  - |x| is computed in WIDTH bits. |0x80000000| = 0x80000000, treated as unsigned.
  - The quotient truncates toward zero. The remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF yields Lo=0x80000000, Hi=0. No overflow flag.
- DivCtrl while busy is ignored. No queuing.
- DivCtrl held high continuously: a new operation starts on the first IDLE edge after done.
- DivCtrl with divisor==0 while busy is ignored; no divZero pulse.
- done and divZero are never high in the same cycle.

Decomposition:
- Shared package cpu_ctrl_pkg holds:
  - The div_unit state encoding (IDLE=2'b00, RUN=2'b01, FIX=2'b10).
  - WIDTH default, DIV_func/DIVM_func constants.
  - The DIV_LATENCY=33 constant, which the controller uses to bound its wait state.
- One natural sub-module: div_step, a combinational single-iteration block.
  - Inputs: rem, quo, divisor magnitude.
  - Outputs: next rem, next quo.
  - Instantiated once inside div_unit.

Test Plan:
- 100 / 7 (DivCtrl pulse in IDLE) -> done exactly 33 edges after start; Lo=14, Hi=2; busy high for 33 cycles.
- -7 / 2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. Also 7 / -2 -> Lo=0xFFFFFFFD, Hi=1.
- 0x80000000 / 0xFFFFFFFF -> Lo=0x80000000, Hi=0. Also 5 / 0x80000000 -> Lo=0, Hi=5.
- 42 / 0 -> divZero=1 for one cycle after start; done never asserted; busy stays 0; Hi/Lo retain the previous values (e.g. 14/2 from the first test).
- Start 100/7, assert DivCtrl with new operands 9/3 at edge E10 -> second request ignored; result Lo=14, Hi=2. Then pulse DivCtrl after done with 9/3 -> Lo=3, Hi=0.
- Start 100/7, assert reset at edge E15 -> all outputs 0 the cycle after; no done or divZero pulse. A new start of 9/3 then completes normally in 33 edges.
